pattern_sequencer: RTL

Controller that sequences the BCD-addressed pattern datapath: a 4-bit BCD address register drives a 16×16 pattern ROM, and a bit-select picks ROM word bit [ADDR]. The block adds a start/done handshake, single-shot and loop modes, hold and abort, and a BCD pass counter. It sits between the test/control logic and the pattern ROM + mux pair, replacing the free-running counter.

---
 rtl/pattern_pkg.sv | 26 ++
 rtl/pattern_rom.sv | 17 +
 rtl/pattern_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, constants and ROM contents for the pattern sequencer
package pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Addresses whose ROM word carries a one-hot bit at its own position.
   localparam logic [15:0] ROM_SET = 16'b0001_1100_0011_1111;

   // ROM word a: one-hot bit a when a is in the set, else all zeros.
   function automatic logic [15:0] rom_word(input logic [3:0] a);
      rom_word = ROM_SET[a] ? (16'd1 << a) : 16'd0;
   endfunction

   // BCD digit increment; 9 wraps to 0 with no carry out.
   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      bcd_inc = (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/pattern_rom.sv
// rtl/pattern_rom.sv - combinational 16x16 pattern ROM with self-indexed bit select
module pattern_rom
   import pattern_pkg::*;
(
   input  logic [3:0] A,
   output logic       B
);

   logic [15:0] word;

   // Fetch word A and pick its bit A.
   always_comb begin
      word = rom_word(A);
      B    = word[A];
   end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - start/done sequencer driving the BCD-addressed pattern ROM
module pattern_sequencer
   import pattern_pkg::*;
#(
   parameter logic [3:0] FIRST = 4'd0,
   parameter logic [3:0] LAST  = 4'd9
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       MODE,
   input  logic       HOLD,
   input  logic       STOP,
   output logic       BUSY,
   output logic       DONE,
   output logic       VALID,
   output logic [3:0] ADDR,
   output logic       OUT,
   output logic [3:0] PASSES
);

   generate
      if (LAST > BCD_MAX || FIRST > LAST) begin : g_bad_params
         $error("pattern_sequencer: need FIRST <= LAST <= 9");
      end
   endgenerate

   state_t state;
   logic   mode_q;
   logic   rom_bit;

   pattern_rom u_rom (
      .A (ADDR),
      .B (rom_bit)
   );

   // OUT follows the registered address with no added latency.
   assign OUT = VALID & rom_bit;

   // Sequencer FSM with BCD address counter and saturating pass counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= ST_IDLE;
         mode_q <= 1'b0;
         ADDR   <= FIRST;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         VALID  <= 1'b0;
         PASSES <= 4'd0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               ADDR  <= FIRST;
               VALID <= 1'b0;
               BUSY  <= 1'b0;
               if (START) begin
                  state  <= ST_RUN;
                  mode_q <= MODE;
                  PASSES <= 4'd0;
                  VALID  <= 1'b1;
                  BUSY   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (STOP) begin
                  state <= ST_IDLE;
                  ADDR  <= FIRST;
                  VALID <= 1'b0;
                  BUSY  <= 1'b0;
               end else if (HOLD) begin
                  state <= ST_PAUSE;
                  VALID <= 1'b0;
               end else if (ADDR != LAST) begin
                  ADDR <= bcd_inc(ADDR);
               end else if (mode_q) begin
                  ADDR <= FIRST;
                  if (PASSES != BCD_MAX) PASSES <= bcd_inc(PASSES);
               end else begin
                  state <= ST_FIN;
                  ADDR  <= FIRST;
                  VALID <= 1'b0;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (STOP) begin
                  state <= ST_IDLE;
                  ADDR  <= FIRST;
                  BUSY  <= 1'b0;
               end else if (!HOLD) begin
                  state <= ST_RUN;
                  VALID <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               ADDR  <= FIRST;
            end
         endcase
      end
   end

endmodule
